loop_sram_ctrl: RTL and testbench
=================================

# loop_sram_ctrl

Looper sequencer that owns the external 16-bit SRAM during the record-loop and play-loop phases of the pedal. It takes one processed audio sample per frame from the effect chain and writes it to SRAM while recording. It then replays the captured loop endlessly, wrapping at the recorded length. A single user key steps it through idle, record and play. It sits between the effect chain output and the DAC mixer, and drives the SRAM pins through a tri-state wrapper at top level.

## Interface
- LOOP_ADDR_W, 20: SRAM word address width.
- LOOP_MAX, 20'hFFFFF: maximum loop length in samples; recording stops automatically at this count.

- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_sample_valid  in  1  one-cycle strobe, one per audio frame.
- i_sample  in  16  signed sample to record; sampled when i_sample_valid=1.
- i_key  in  1  debounced one-cycle press pulse; advances the looper state.
- i_clear  in  1  one-cycle pulse; discards the loop and returns to idle.
- o_play_sample  out  16  signed loop sample; held between strobes.
- o_play_valid  out  1  one-cycle strobe when o_play_sample updates.
- o_state  out  2  looper state: 0 IDLE, 1 REC, 2 PLAY, 3 OVERDUB.
- o_loop_len  out  LOOP_ADDR_W  recorded length in samples.
- o_overrun  out  1  one-cycle pulse when a strobe is dropped.
- o_SRAM_ADDR  out  20  word address.
- o_sram_wdata  out  16  write data.
- o_sram_dq_oe  out  1  1 = drive io_SRAM_DQ with o_sram_wdata.
- i_sram_rdata  in  16  io_SRAM_DQ as read back.
- o_SRAM_WE_N, o_SRAM_OE_N  out  1 each  active-low write enable and output enable.
- o_SRAM_CE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  tied 0 (chip and both byte lanes always enabled).

## Operation
- **Looper FSM**
  - IDLE: i_key → REC, with the write pointer wp=0.
  - REC: i_key → PLAY, with o_loop_len=wp and the read pointer rp=0.
  - REC with wp=0 at the key press: → IDLE instead, and o_loop_len stays 0.
  - REC when wp reaches LOOP_MAX: → PLAY automatically, with o_loop_len=LOOP_MAX.
  - PLAY: i_key is ignored unless LOOP_OVERDUB_EN is defined (see Configuration).
  - Any state: i_clear → IDLE, o_loop_len=0, wp=rp=0.
  - i_clear takes priority over i_key in the same cycle.
- **Access FSM**, which runs once per accepted strobe: A_IDLE → (A_WR | A_RD → A_CAP [→ A_WR]) → A_IDLE.
  - REC: A_WR, writing i_sample at address wp, then wp+1.
  - PLAY: A_RD at address rp, then A_CAP latches i_sram_rdata into o_play_sample, pulses o_play_valid and advances rp.
  - rp wraps: if rp+1 == o_loop_len, rp becomes 0.
  - IDLE: no SRAM access; o_play_sample=0; no o_play_valid pulse.
- **Strobe arbitration**
  - A strobe that arrives while the access FSM is not in A_IDLE is dropped and o_overrun pulses.
  - i_sample is captured at strobe time, so later changes do not corrupt the write.
- **Looper transitions during an access** take effect at the next strobe; the in-flight access completes with the old state's addresses.
- **Reset values:** state IDLE, access A_IDLE.
  - o_play_sample=0, o_play_valid=0, o_loop_len=0, o_overrun=0.
  - o_SRAM_ADDR=0, o_sram_wdata=0, o_sram_dq_oe=0.
  - o_SRAM_WE_N=1, o_SRAM_OE_N=1.
  - o_SRAM_CE_N=o_SRAM_LB_N=o_SRAM_UB_N=0.
- **Reset mid-access:** the access is aborted, WE_N/OE_N return to 1 at once, and the loop is lost.

## Timing
- Strobe at cycle 0 → access FSM leaves A_IDLE at cycle 1.
- A_WR (one cycle):
  - o_SRAM_ADDR and o_sram_wdata are stable.
  - o_sram_dq_oe=1 and WE_N=0 for exactly that cycle.
- A_RD (one cycle): OE_N=0 and o_sram_dq_oe=0.
- A_CAP (one cycle):
  - OE_N stays 0; i_sram_rdata is registered at the end of the cycle.
  - o_play_valid=1 on cycle 3 after the strobe.
- Worst-case access is 4 cycles (overdub). Strobes must be at least 5 cycles apart.
- o_state and o_loop_len update on the cycle after i_key or i_clear.

## Configuration
- Macro: LOOP_OVERDUB_EN.
- Defined:
  - PLAY + i_key → OVERDUB; OVERDUB + i_key → PLAY.
  - OVERDUB runs A_RD → A_CAP → A_WR at address rp.
  - The written word is the saturating signed sum of the read data and i_sample, clamped to the range 16'h8000..16'h7FFF.
  - o_play_sample in OVERDUB is the read data, i.e. the sample before the sum.
- Undefined: state 3 is unreachable, i_key in PLAY is ignored, and the adder is not instantiated.

## Structure
- Package loop_pkg:
  - looper state enum: IDLE, REC, PLAY, OVERDUB;
  - access enum: A_IDLE, A_RD, A_CAP, A_WR;
  - LOOP_ADDR_W and LOOP_MAX defaults.
- Sub-module loop_mix_sat: 16-bit signed saturating adder, purely combinational. It is instantiated only under LOOP_OVERDUB_EN.

## Test plan
- **Reset:** hold i_rst_n=0 → all outputs at their reset values, WE_N=OE_N=1.
- **Record then play:**
  - Stimulus: key, strobes with samples 1..5, key.
  - o_loop_len=5.
  - The next 7 strobes give o_play_sample 1,2,3,4,5,1,2, each o_play_valid 3 cycles after its strobe.
- **Empty record:** key, key with no strobes → o_state back to 0, o_loop_len=0.
- **Auto stop:** with LOOP_MAX=4, key and 6 strobes → o_state=2 after the 4th write, o_loop_len=4, and the 5th strobe performs a read.
- **Overrun:** two strobes 2 cycles apart during PLAY → the second is dropped, one o_overrun pulse, rp advances by 1.
- **Overdub** (LOOP_OVERDUB_EN):
  - Setup: loop [16'h7000, 16'h0001]; key into OVERDUB; strobes with i_sample 16'h2000 and 16'hFFFF.
  - SRAM then holds [16'h7FFF, 16'h0000].
  - Mid-access i_clear → the access completes, then o_state=0.

Source files
------------

// File: rtl/loop_pkg.sv
// Shared types and defaults for the loop SRAM sequencer.
package loop_pkg;

  localparam int unsigned             LOOP_ADDR_W = 20;
  localparam logic [LOOP_ADDR_W-1:0]  LOOP_MAX    = 20'hFFFFF;
  localparam int unsigned             SAMPLE_W    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REC     = 2'd1,
    PLAY    = 2'd2,
    OVERDUB = 2'd3
  } loop_state_e;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_RD   = 2'd1,
    A_CAP  = 2'd2,
    A_WR   = 2'd3
  } acc_state_e;

endpackage

// File: rtl/loop_mix_sat.sv
// 16-bit signed saturating adder for overdub mixing; only built when LOOP_OVERDUB_EN is defined.
`ifdef LOOP_OVERDUB_EN
module loop_mix_sat
  import loop_pkg::*;
(
  input  logic [SAMPLE_W-1:0] i_a,
  input  logic [SAMPLE_W-1:0] i_b,
  output logic [SAMPLE_W-1:0] o_sum_c
);

  logic [SAMPLE_W:0] w_sum;

  // One guard bit; overflow shows as disagreement between the top two bits.
  always_comb begin
    w_sum   = {i_a[SAMPLE_W-1], i_a} + {i_b[SAMPLE_W-1], i_b};
    o_sum_c = w_sum[SAMPLE_W-1:0];
    if (w_sum[SAMPLE_W] != w_sum[SAMPLE_W-1]) begin
      o_sum_c = w_sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

endmodule
`endif

// File: rtl/loop_sram_ctrl.sv
// Looper sequencer: records one sample per frame into external SRAM, then replays it as a loop.
// Define LOOP_OVERDUB_EN to add the OVERDUB state (read, saturating mix, write back).
module loop_sram_ctrl #(
  parameter int unsigned             LOOP_ADDR_W = loop_pkg::LOOP_ADDR_W,
  parameter logic [LOOP_ADDR_W-1:0]  LOOP_MAX    = LOOP_ADDR_W'(loop_pkg::LOOP_MAX)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_sample_valid,
  input  logic [loop_pkg::SAMPLE_W-1:0] i_sample,
  input  logic                          i_key,
  input  logic                          i_clear,
  output logic [loop_pkg::SAMPLE_W-1:0] o_play_sample,
  output logic                          o_play_valid,
  output logic [1:0]                    o_state,
  output logic [LOOP_ADDR_W-1:0]        o_loop_len,
  output logic                          o_overrun,
  output logic [LOOP_ADDR_W-1:0]        o_SRAM_ADDR,
  output logic [loop_pkg::SAMPLE_W-1:0] o_sram_wdata,
  output logic                          o_sram_dq_oe,
  input  logic [loop_pkg::SAMPLE_W-1:0] i_sram_rdata,
  output logic                          o_SRAM_WE_N,
  output logic                          o_SRAM_OE_N,
  output logic                          o_SRAM_CE_N,
  output logic                          o_SRAM_LB_N,
  output logic                          o_SRAM_UB_N
);
  import loop_pkg::*;

  loop_state_e              r_state, w_state_nxt, r_kind;
  acc_state_e               r_acc, w_acc_nxt;
  logic [LOOP_ADDR_W-1:0]   r_wp, r_rp, r_len, r_addr;
  logic [LOOP_ADDR_W-1:0]   w_wp_nxt, w_rp_nxt, w_len_nxt, w_wp_inc, w_rp_inc;
  logic [SAMPLE_W-1:0]      r_play_sample, r_wdata, w_ovd_wdata;
  logic                     r_play_valid, r_overrun, r_dq_oe, r_we_n, r_oe_n;
  logic                     w_accept, w_drop, w_idle_strobe, w_wr_done, w_cap_done;

`ifdef LOOP_OVERDUB_EN
  logic [SAMPLE_W-1:0] r_ovd_sample;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_ovd_sample <= '0;
    else if (w_accept) r_ovd_sample <= i_sample;
  end

  loop_mix_sat u_mix (
    .i_a     (i_sram_rdata),
    .i_b     (r_ovd_sample),
    .o_sum_c (w_ovd_wdata)
  );
`else
  assign w_ovd_wdata = i_sram_rdata;
`endif

  assign w_accept      = i_sample_valid && (r_acc == A_IDLE) && (r_state != IDLE);
  assign w_idle_strobe = i_sample_valid && (r_acc == A_IDLE) && (r_state == IDLE);
  assign w_drop        = i_sample_valid && (r_acc != A_IDLE);
  assign w_wr_done     = (r_acc == A_WR) && (r_kind == REC);
  assign w_cap_done    = (r_acc == A_CAP);
  assign w_wp_inc      = r_wp + LOOP_ADDR_W'(1);
  assign w_rp_inc      = r_rp + LOOP_ADDR_W'(1);

  // Access sequencer: one pass per accepted strobe, kind fixed at strobe time.
  always_comb begin
    w_acc_nxt = r_acc;
    case (r_acc)
      A_IDLE: if (w_accept) w_acc_nxt = (r_state == REC) ? A_WR : A_RD;
      A_RD:   w_acc_nxt = A_CAP;
      A_CAP:  w_acc_nxt = (r_kind == OVERDUB) ? A_WR : A_IDLE;
      A_WR:   w_acc_nxt = A_IDLE;
    endcase
  end

  // Looper state and pointers; clear overrides key, key overrides auto-stop.
  always_comb begin
    w_state_nxt = r_state;
    w_wp_nxt    = r_wp;
    w_rp_nxt    = r_rp;
    w_len_nxt   = r_len;
    if (w_wr_done) w_wp_nxt = w_wp_inc;
    if (w_cap_done) w_rp_nxt = (w_rp_inc == r_len) ? '0 : w_rp_inc;
    if (w_wr_done && (r_state == REC) && (w_wp_inc == LOOP_MAX)) begin
      w_state_nxt = PLAY;
      w_len_nxt   = LOOP_MAX;
      w_rp_nxt    = '0;
    end
    if (i_key) begin
      case (r_state)
        IDLE: begin
          w_state_nxt = REC;
          w_wp_nxt    = '0;
        end
        REC: begin
          if (r_wp == '0) begin
            w_state_nxt = IDLE;
            w_len_nxt   = '0;
          end else begin
            w_state_nxt = PLAY;
            w_len_nxt   = r_wp;
            w_rp_nxt    = '0;
          end
        end
        PLAY: begin
`ifdef LOOP_OVERDUB_EN
          w_state_nxt = OVERDUB;
`endif
        end
        OVERDUB: w_state_nxt = PLAY;
      endcase
    end
    if (i_clear) begin
      w_state_nxt = IDLE;
      w_len_nxt   = '0;
      w_wp_nxt    = '0;
      w_rp_nxt    = '0;
    end
  end

  // SRAM strobes are registered from the next access state so they align with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_acc         <= A_IDLE;
      r_kind        <= IDLE;
      r_wp          <= '0;
      r_rp          <= '0;
      r_len         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_dq_oe       <= 1'b0;
      r_we_n        <= 1'b1;
      r_oe_n        <= 1'b1;
      r_play_sample <= '0;
      r_play_valid  <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_wp         <= w_wp_nxt;
      r_rp         <= w_rp_nxt;
      r_len        <= w_len_nxt;
      r_we_n       <= (w_acc_nxt != A_WR);
      r_oe_n       <= !((w_acc_nxt == A_RD) || (w_acc_nxt == A_CAP));
      r_dq_oe      <= (w_acc_nxt == A_WR);
      r_play_valid <= w_cap_done;
      r_overrun    <= w_drop;
      if (w_accept) begin
        r_kind  <= r_state;
        r_addr  <= (r_state == REC) ? r_wp : r_rp;
        r_wdata <= i_sample;
      end
      if (w_cap_done && (r_kind == OVERDUB)) r_wdata <= w_ovd_wdata;
      if (w_cap_done)         r_play_sample <= i_sram_rdata;
      else if (w_idle_strobe) r_play_sample <= '0;
    end
  end

  assign o_play_sample = r_play_sample;
  assign o_play_valid  = r_play_valid;
  assign o_state       = r_state;
  assign o_loop_len    = r_len;
  assign o_overrun     = r_overrun;
  assign o_SRAM_ADDR   = r_addr;
  assign o_sram_wdata  = r_wdata;
  assign o_sram_dq_oe  = r_dq_oe;
  assign o_SRAM_WE_N   = r_we_n;
  assign o_SRAM_OE_N   = r_oe_n;
  assign o_SRAM_CE_N   = 1'b0;
  assign o_SRAM_LB_N   = 1'b0;
  assign o_SRAM_UB_N   = 1'b0;

endmodule

// File: tb/tb_loop_sram_ctrl.sv
// Scoreboard bench for loop_sram_ctrl: a behavioural looper model predicts reads and writes,
// a negedge monitor pops and compares. Overdub scenarios run when LOOP_OVERDUB_EN is defined.
module tb_loop_sram_ctrl;

  localparam int unsigned AW   = 20;
  localparam int          LMAX = 8;

  logic          clk, rst_n, sample_valid, key, clear;
  logic [15:0]   sample, play_sample, sram_wdata, sram_rdata;
  logic          play_valid, overrun, dq_oe, we_n, oe_n, ce_n, lb_n, ub_n;
  logic [1:0]    state;
  logic [AW-1:0] loop_len, sram_addr;

  loop_sram_ctrl #(.LOOP_ADDR_W(AW), .LOOP_MAX(AW'(LMAX))) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample_valid (sample_valid),
    .i_sample       (sample),
    .i_key          (key),
    .i_clear        (clear),
    .o_play_sample  (play_sample),
    .o_play_valid   (play_valid),
    .o_state        (state),
    .o_loop_len     (loop_len),
    .o_overrun      (overrun),
    .o_SRAM_ADDR    (sram_addr),
    .o_sram_wdata   (sram_wdata),
    .o_sram_dq_oe   (dq_oe),
    .i_sram_rdata   (sram_rdata),
    .o_SRAM_WE_N    (we_n),
    .o_SRAM_OE_N    (oe_n),
    .o_SRAM_CE_N    (ce_n),
    .o_SRAM_LB_N    (lb_n),
    .o_SRAM_UB_N    (ub_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple SRAM: combinational read while OE_N low, write on the clock while WE_N low.
  logic [15:0] mem [0:255];
  assign sram_rdata = (!oe_n) ? mem[sram_addr[7:0]] : 16'hBAD0;
  always @(posedge clk) if (!we_n && dq_oe) mem[sram_addr[7:0]] <= sram_wdata;

  int total = 0, bad = 0, cyc = 0, n_ovr = 0, exp_ovr = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [15:0] d; int c; } play_t;
  typedef struct packed { int a; logic [15:0] d; int c; } wr_t;
  play_t play_q[$];
  wr_t   wr_q[$];

  int          m_state = 0, m_wp = 0, m_rp = 0, m_len = 0;
  logic [15:0] m_mem [0:255];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  // Looper behaviour expressed as plain bookkeeping over a loop buffer.
  task automatic model_strobe(input logic [15:0] s);
    logic [15:0] r;
    case (m_state)
      1: begin
        wr_q.push_back('{a: m_wp, d: s, c: cyc + 1});
        m_mem[m_wp] = s;
        m_wp++;
        if (m_wp == LMAX) begin m_state = 2; m_len = LMAX; m_rp = 0; end
      end
      2: begin
        play_q.push_back('{d: m_mem[m_rp], c: cyc + 3});
        m_rp = (m_rp + 1) % m_len;
      end
      3: begin
        r = m_mem[m_rp];
        play_q.push_back('{d: r, c: cyc + 3});
        m_mem[m_rp] = sat_add(r, s);
        wr_q.push_back('{a: m_rp, d: m_mem[m_rp], c: cyc + 3});
        m_rp = (m_rp + 1) % m_len;
      end
      default: ;
    endcase
  endtask

  task automatic model_key();
    case (m_state)
      0: begin m_state = 1; m_wp = 0; end
      1: if (m_wp == 0) begin m_state = 0; m_len = 0; end
         else begin m_state = 2; m_len = m_wp; m_rp = 0; end
`ifdef LOOP_OVERDUB_EN
      2: m_state = 3;
`endif
      3: m_state = 2;
      default: ;
    endcase
  endtask

  task automatic model_clear();
    m_state = 0; m_len = 0; m_wp = 0; m_rp = 0;
  endtask

  // Monitor: every DUT read/write/overrun event is compared against the queues.
  play_t p;
  wr_t   w;
  always @(negedge clk) begin
    if (rst_n) begin
      if (play_valid) begin
        if (play_q.size() == 0) chk("spurious_play_valid", 32'(play_valid), 32'd0);
        else begin
          p = play_q.pop_front();
          chk("play_sample", 32'(play_sample), 32'(p.d));
          chk("play_latency", 32'(cyc), 32'(p.c));
        end
      end
      if (!we_n) begin
        if (wr_q.size() == 0) chk("spurious_write", 32'(!we_n), 32'd0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", 32'(sram_addr), 32'(w.a));
          chk("wr_data", 32'(sram_wdata), 32'(w.d));
          chk("wr_cycle", 32'(cyc), 32'(w.c));
          chk("wr_dq_oe", 32'(dq_oe), 32'd1);
        end
      end else if (dq_oe) chk("dq_oe_without_we", 32'(dq_oe), 32'd0);
      if (overrun) n_ovr++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] s, input int gap);
    sample_valid = 1'b1;
    sample       = s;
    model_strobe(s);
    step(1);
    sample_valid = 1'b0;
    sample       = 16'($urandom);
    step(gap - 1);
  endtask

  task automatic key_press();
    key = 1'b1;
    model_key();
    step(1);
    key = 1'b0;
    chk("state_after_key", 32'(state), 32'(m_state));
    chk("len_after_key", 32'(loop_len), 32'(m_len));
    step(1);
  endtask

  task automatic clear_press();
    clear = 1'b1;
    model_clear();
    step(1);
    clear = 1'b0;
    chk("state_after_clear", 32'(state), 32'd0);
    chk("len_after_clear", 32'(loop_len), 32'd0);
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    rst_n = 1'b0; sample_valid = 1'b0; key = 1'b0; clear = 1'b0; sample = '0;
    step(3);
    chk("rst_play_sample", 32'(play_sample), 32'd0);
    chk("rst_play_valid", 32'(play_valid), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_loop_len", 32'(loop_len), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_wdata", 32'(sram_wdata), 32'd0);
    chk("rst_dq_oe", 32'(dq_oe), 32'd0);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_ce_lb_ub", 32'({ce_n, lb_n, ub_n}), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Record 1..5, then play seven frames across the wrap.
    key_press();
    for (int i = 1; i <= 5; i++) strobe(16'(i), 6);
    key_press();
    chk("rec_len", 32'(loop_len), 32'd5);
    for (int i = 0; i < 7; i++) strobe(16'($urandom), 5 + (i % 3));

    // Second strobe two cycles after the first is dropped.
    sample_valid = 1'b1; sample = 16'h1111; model_strobe(16'h1111);
    step(1); sample_valid = 1'b0;
    step(1); sample_valid = 1'b1; sample = 16'h2222; exp_ovr++;
    step(1); sample_valid = 1'b0;
    step(6);
    chk("overrun_pulses", 32'(n_ovr), 32'(exp_ovr));
    strobe(16'h0, 6);

    // Empty record and idle strobe.
    clear_press();
    key_press();
    key_press();
    chk("empty_rec_state", 32'(state), 32'd0);
    chk("empty_rec_len", 32'(loop_len), 32'd0);
    strobe(16'h5A5A, 6);
    chk("idle_play_sample", 32'(play_sample), 32'd0);

    // Auto stop at LOOP_MAX, then reads follow.
    key_press();
    for (int i = 0; i < LMAX + 2; i++) begin
      strobe(16'(16'h0100 + i), 6);
      if (i == LMAX - 1) begin
        chk("autostop_state", 32'(state), 32'd2);
        chk("autostop_len", 32'(loop_len), 32'(LMAX));
      end
    end

    // Randomized sessions.
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 99);
      if (op < 78)      strobe(16'($urandom), $urandom_range(5, 8));
      else if (op < 96) key_press();
      else              clear_press();
    end

`ifdef LOOP_OVERDUB_EN
    clear_press();
    key_press();
    strobe(16'h7000, 6);
    strobe(16'h0001, 6);
    key_press();
    key_press();
    chk("overdub_state", 32'(state), 32'd3);
    strobe(16'h2000, 6);
    strobe(16'hFFFF, 6);
    chk("overdub_mem0", 32'(mem[0]), 32'h7FFF);
    chk("overdub_mem1", 32'(mem[1]), 32'h0000);
    sample_valid = 1'b1; sample = 16'h0010; model_strobe(16'h0010);
    step(1); sample_valid = 1'b0;
    clear = 1'b1; model_clear();
    step(1); clear = 1'b0;
    step(5);
    chk("overdub_clear_state", 32'(state), 32'd0);
    chk("overdub_clear_mem0", 32'(mem[0]), 32'h7FFF);
`endif

    // Reset during a read and during a write releases the SRAM strobes at once.
    clear_press();
    key_press();
    strobe(16'hAAAA, 6);
    strobe(16'hBBBB, 6);
    key_press();
    sample_valid = 1'b1; sample = 16'h0; model_strobe(16'h0);
    step(1); sample_valid = 1'b0;
    chk("mid_read_oe_n", 32'(oe_n), 32'd0);
    rst_n = 1'b0; #1;
    chk("rst_mid_read_oe_n", 32'(oe_n), 32'd1);
    chk("rst_mid_read_state", 32'(state), 32'd0);
    chk("rst_mid_read_len", 32'(loop_len), 32'd0);
    play_q.delete(); wr_q.delete(); model_clear();
    step(2); rst_n = 1'b1; step(2);
    key_press();
    sample_valid = 1'b1; sample = 16'hCCCC; model_strobe(16'hCCCC);
    step(1); sample_valid = 1'b0;
    chk("mid_write_we_n", 32'(we_n), 32'd0);
    rst_n = 1'b0; #1;
    chk("rst_mid_write_we_n", 32'(we_n), 32'd1);
    chk("rst_mid_write_dq_oe", 32'(dq_oe), 32'd0);
    play_q.delete(); wr_q.delete(); model_clear();
    step(2); rst_n = 1'b1; step(2);

    step(10);
    chk("play_queue_drained", 32'(play_q.size()), 32'd0);
    chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("overrun_total", 32'(n_ovr), 32'(exp_ovr));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
